// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Covers the FSM encodings, the scoreboard entry layout and the flush depth.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int REG_W        = 5;
    localparam int ENTRY_W      = REG_W + 3;
    localparam int DEST_LSB     = 0;
    localparam int MEMREAD_BIT  = REG_W;
    localparam int REGWRITE_BIT = REG_W + 1;
    localparam int VALID_BIT    = REG_W + 2;

    localparam logic [REG_W-1:0] REG_ZERO    = '0;
    localparam logic [1:0]       FLUSH_DEPTH = 2'd3;

    typedef struct packed {
        logic             valid;
        logic             regwrite;
        logic             memread;
        logic [REG_W-1:0] dest;
    } sb_entry_t;

    // $0 is hard-wired, so a write to it can never create a dependency.
    function automatic logic sb_match(input sb_entry_t e, input logic [REG_W-1:0] r);
        return e.valid & e.regwrite & (e.dest != REG_ZERO) & (e.dest == r);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry shift register of in-flight destinations (EX -> MEM -> WB).
// EX can take a bubble instead of the ID entry; MEM can be cleared by a flush.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  sb_entry_t id_entry,
    input  logic      insert_bubble,
    input  logic      clear_mem,
    output sb_entry_t ex_entry,
    output sb_entry_t mem_entry,
    output sb_entry_t wb_entry
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_entry  <= '0;
            mem_entry <= '0;
            wb_entry  <= '0;
        end else begin
            wb_entry  <= mem_entry;
            mem_entry <= clear_mem ? '0 : ex_entry;
            ex_entry  <= insert_bubble ? '0 : id_entry;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: RAW detection against the IF/ID
// instruction, stall/bubble/flush generation, sequencing FSM and event counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | normal issue
// ST_STALL | IF/ID instruction held behind an unresolved producer
// ST_FLUSH | squashing the wrong-path instructions behind a taken branch
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FORWARDING = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             id_uses_rt,
    input  logic             id_RegDst,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t     state_q, state_d;
    logic [1:0] flush_left_q, flush_left_d;
    sb_entry_t  id_entry, ex_entry, mem_entry, wb_entry;
    logic       hz_ex, hz_mem, hazard, eff_branch, stall_inc;

    always_comb begin
        id_entry          = '0;
        id_entry.valid    = id_valid;
        id_entry.regwrite = id_RegWrite;
        id_entry.memread  = id_MemRead;
        id_entry.dest     = id_RegDst ? id_rd : id_rt;
    end

    hazard_scoreboard u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .id_entry      (id_entry),
        .insert_bubble (idex_bubble | ~id_valid),
        .clear_mem     (eff_branch),
        .ex_entry      (ex_entry),
        .mem_entry     (mem_entry),
        .wb_entry      (wb_entry)
    );

    // WB is never compared: the register file writes before it reads.
    always_comb begin
        hz_ex  = sb_match(ex_entry, id_rs)  | (id_uses_rt & sb_match(ex_entry, id_rt));
        hz_mem = sb_match(mem_entry, id_rs) | (id_uses_rt & sb_match(mem_entry, id_rt));
        if (FORWARDING != 0)
            hazard = id_valid & ex_entry.memread & hz_ex;
        else
            hazard = id_valid & (hz_ex | hz_mem);
    end

    assign eff_branch = branch_taken & (state_q != ST_FLUSH);
    assign stall_inc  = hazard & ~eff_branch;

    // A taken branch squashes the stalled instruction, so it overrides the stall.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        if (eff_branch) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        flush_left_d = flush_left_q;
        if (eff_branch) begin
            state_d      = ST_FLUSH;
            flush_left_d = FLUSH_DEPTH;
        end else begin
            case (state_q)
                ST_RUN:   if (hazard)  state_d = ST_STALL;
                ST_STALL: if (!hazard) state_d = ST_RUN;
                ST_FLUSH: begin
                    flush_left_d = flush_left_q - 2'd1;
                    if (flush_left_q <= 2'd1) begin
                        state_d      = hazard ? ST_STALL : ST_RUN;
                        flush_left_d = 2'd0;
                    end
                end
                default:  state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            flush_left_q <= 2'd0;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            state_q      <= state_d;
            flush_left_q <= flush_left_d;
            if (stall_inc && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (eff_branch && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign state = state_q;

endmodule
